// File: rtl/stream_mux_arb_pkg.sv
// Shared constants for the streaming N-way mux/arbiter.
package stream_mux_arb_pkg;

  localparam logic ModeSel = 1'b0;
  localparam logic ModeRr  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping past N-1.
module rr_arbiter #(
  parameter int N = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            gvalid
);

  localparam int DW = $clog2(2 * N);

  logic [2*N-1:0] dbl;
  logic [DW-1:0]  idx;

  // Scanning the doubled request vector from ptr turns the wrap into a linear search.
  always_comb begin
    dbl    = {req, req};
    grant  = '0;
    gvalid = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = DW'(ptr) + DW'(k);
      if (!gvalid && dbl[idx]) begin
        gvalid = 1'b1;
        grant  = (idx >= DW'(N)) ? SELW'(idx - DW'(N)) : SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-way valid/ready stream mux with external-select or round-robin grant and a
// one-entry registered output stage.
module stream_mux_arb
  import stream_mux_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 rr_en,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int SelSpan = 2 ** SELW;

  logic [SELW-1:0]    ptr;
  logic [SELW-1:0]    rr_grant;
  logic [SELW-1:0]    grant;
  logic               rr_gvalid;
  logic               gvalid;
  logic               load_en;
  logic               xfer;
  logic [SelSpan-1:0] valid_pad;
  logic [WIDTH-1:0]   chans [N];
  logic [WIDTH-1:0]   sel_data;

  rr_arbiter #(
    .N(N)
  ) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (rr_grant),
    .gvalid(rr_gvalid)
  );

  for (genvar i = 0; i < N; i++) begin : g_chan
    assign chans[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Zero-padding makes out-of-range sel values read as "not valid".
  assign valid_pad = SelSpan'(in_valid);

  always_comb begin
    grant  = sel;
    gvalid = 1'b0;
    unique case (rr_en)
      ModeSel: begin
        grant  = sel;
        gvalid = valid_pad[sel];
      end
      ModeRr: begin
        grant  = rr_grant;
        gvalid = rr_gvalid;
      end
    endcase
  end

  assign load_en = !out_valid || out_ready;
  assign xfer    = load_en && gvalid && !reset;

  always_comb begin
    sel_data = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) begin
        sel_data    = chans[i];
        in_ready[i] = xfer;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_chan  <= grant;
      if (rr_en == ModeRr) begin
        ptr <= (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb: directed scenarios plus a randomized run
// against a queue-free behavioural model (N=8/WIDTH=16 and N=5/WIDTH=8 builds).
module tb_stream_mux_arb;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int SW = 3;
  localparam int W5 = 8;
  localparam int N5 = 5;
  localparam int SW5 = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  sel;
  logic           rr_en;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;

  logic [N5*W5-1:0] in_data5;
  logic [N5-1:0]    in_valid5;
  logic [N5-1:0]    in_ready5;
  logic [SW5-1:0]   sel5;
  logic             rr_en5;
  logic [W5-1:0]    out_data5;
  logic [SW5-1:0]   out_chan5;
  logic             out_valid5;
  logic             out_ready5;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_chan;
  int           m_ptr;

  stream_mux_arb #(
    .WIDTH(W),
    .N    (N)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .rr_en    (rr_en),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  stream_mux_arb #(
    .WIDTH(W5),
    .N    (N5)
  ) dut5 (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data5),
    .in_valid (in_valid5),
    .in_ready (in_ready5),
    .sel      (sel5),
    .rr_en    (rr_en5),
    .out_data (out_data5),
    .out_chan (out_chan5),
    .out_valid(out_valid5),
    .out_ready(out_ready5)
  );

  // Returns the granted channel, or -1 when nothing transfers.
  function automatic int model_grant(input logic rr, input int s, input logic [N-1:0] v,
                                     input int p);
    if (!rr) return (s < N && v[s]) ? s : -1;
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset      = 1'b1;
    in_data    = '0;
    in_valid   = '0;
    sel        = '0;
    rr_en      = 1'b0;
    out_ready  = 1'b0;
    in_data5   = '0;
    in_valid5  = '0;
    sel5       = '0;
    rr_en5     = 1'b0;
    out_ready5 = 1'b0;
    repeat (2) @(negedge clock);
    reset   = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_ptr   = 0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 8'hFF;
    rr_en    = 1'b0;
    sel      = '0;
    in_data  = '0;
    out_ready = 1'b0;
    in_valid5 = '0;
    sel5 = '0;
    rr_en5 = 1'b0;
    out_ready5 = 1'b0;
    in_data5 = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_chan !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got valid=%0b data=%h chan=%0d exp valid=0 data=0000 chan=0",
               out_valid, out_data, out_chan);
    end
    checks++;
    if (in_ready !== 8'h00) begin
      failures++;
      $display("FAIL reset_in_ready got=%h exp=00", in_ready);
    end
    // Load BEEF and hold it, then reset between edges.
    reset = 1'b0;
    in_valid = 8'h08;
    sel = 3'd3;
    in_data[3*W +: W] = 16'hBEEF;
    @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_chan !== 3'd3) begin
      failures++;
      $display("FAIL preload got valid=%0b data=%h chan=%0d exp valid=1 data=beef chan=3",
               out_valid, out_data, out_chan);
    end
    @(negedge clock);
    in_valid = '0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_chan !== 3'd0) begin
      failures++;
      $display("FAIL async_reset got valid=%0b data=%h chan=%0d exp valid=0 data=0000 chan=0",
               out_valid, out_data, out_chan);
    end
    #1 reset = 1'b0;
    @(negedge clock);
    rr_en = 1'b1;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 8'h01) begin
      failures++;
      $display("FAIL post_reset_rr_ready got=%h exp=01", in_ready);
    end
    @(posedge clock);
    #1;
    checks++;
    if (out_chan !== 3'd0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_rr_chan got chan=%0d valid=%0b exp chan=0 valid=1",
               out_chan, out_valid);
    end
  endtask

  task automatic test_sel();
    do_reset();
    rr_en = 1'b0;
    sel = 3'd5;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
    in_data[5*W +: W] = 16'h1234;
    #1;
    checks++;
    if (in_ready !== 8'h20) begin
      failures++;
      $display("FAIL sel_ready got=%h exp=20", in_ready);
    end
    @(posedge clock);
    #1;
    checks++;
    if (out_data !== 16'h1234 || out_chan !== 3'd5 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL sel_out got data=%h chan=%0d valid=%0b exp data=1234 chan=5 valid=1",
               out_data, out_chan, out_valid);
    end
    @(negedge clock);
  endtask

  task automatic test_rr_wrap();
    do_reset();
    rr_en = 1'b1;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(16'hA000 + i);
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (in_ready !== 8'(1 << (c % N))) begin
        failures++;
        $display("FAIL rr_wrap_ready[%0d] got=%h exp=%h", c, in_ready, 8'(1 << (c % N)));
      end
      @(posedge clock);
      #1;
      checks++;
      if (out_chan !== SW'(c % N) || out_data !== W'(16'hA000 + c % N)) begin
        failures++;
        $display("FAIL rr_wrap_out[%0d] got chan=%0d data=%h exp chan=%0d data=%h",
                 c, out_chan, out_data, c % N, 16'hA000 + c % N);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_backpressure();
    // Output holds channel 1 (A001) from the wrap test.
    out_ready = 1'b0;
    in_valid = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
      #1;
      checks++;
      if (in_ready !== 8'h00) begin
        failures++;
        $display("FAIL bp_ready[%0d] got=%h exp=00", c, in_ready);
      end
      @(posedge clock);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hA001 || out_chan !== 3'd1) begin
        failures++;
        $display("FAIL bp_hold[%0d] got valid=%0b data=%h chan=%0d exp valid=1 data=a001 chan=1",
                 c, out_valid, out_data, out_chan);
      end
      @(negedge clock);
    end
    in_valid = '0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 8'h00) begin
      failures++;
      $display("FAIL bp_release_ready got=%h exp=00", in_ready);
    end
    @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'hA001 || out_chan !== 3'd1) begin
      failures++;
      $display("FAIL bp_drain got valid=%0b data=%h chan=%0d exp valid=0 data=a001 chan=1",
               out_valid, out_data, out_chan);
    end
    @(negedge clock);
  endtask

  task automatic test_sparse();
    do_reset();
    rr_en = 1'b1;
    out_ready = 1'b1;
    in_valid = 8'h20;
    @(posedge clock);
    #1;
    checks++;
    if (out_chan !== 3'd5) begin
      failures++;
      $display("FAIL sparse_prime got chan=%0d exp=5", out_chan);
    end
    @(negedge clock);
    in_valid = 8'b0000_0101;
    #1;
    checks++;
    if (in_ready !== 8'h01) begin
      failures++;
      $display("FAIL sparse_first_ready got=%h exp=01", in_ready);
    end
    @(posedge clock);
    #1;
    checks++;
    if (out_chan !== 3'd0) begin
      failures++;
      $display("FAIL sparse_first_chan got=%0d exp=0", out_chan);
    end
    @(negedge clock);
    #1;
    checks++;
    if (in_ready !== 8'h04) begin
      failures++;
      $display("FAIL sparse_second_ready got=%h exp=04", in_ready);
    end
    @(posedge clock);
    #1;
    checks++;
    if (out_chan !== 3'd2) begin
      failures++;
      $display("FAIL sparse_second_chan got=%0d exp=2", out_chan);
    end
    @(negedge clock);
  endtask

  task automatic test_random();
    int g;
    logic [N-1:0] exp_ready;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rr_en = 1'($urandom);
      sel = SW'($urandom);
      in_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom & $urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
      g = model_grant(rr_en, int'(sel), in_valid, m_ptr);
      exp_ready = ((!m_valid || out_ready) && g >= 0) ? N'(1 << g) : '0;
      #1;
      checks++;
      if (in_ready !== exp_ready) begin
        failures++;
        $display("FAIL rand_ready[%0d] got=%h exp=%h", c, in_ready, exp_ready);
      end
      @(posedge clock);
      if ((!m_valid || out_ready) && g >= 0) begin
        m_valid = 1'b1;
        m_data = in_data[g*W +: W];
        m_chan = g;
        if (rr_en) m_ptr = (g + 1) % N;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      #1;
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_chan !== SW'(m_chan)) begin
        failures++;
        $display("FAIL rand_out[%0d] got valid=%0b data=%h chan=%0d exp valid=%0b data=%h chan=%0d",
                 c, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_n5();
    do_reset();
    for (int i = 0; i < N5; i++) in_data5[i*W5 +: W5] = W5'(8'h50 + i);
    in_valid5 = 5'h1F;
    out_ready5 = 1'b1;
    rr_en5 = 1'b0;
    for (int s = 6; s < 8; s++) begin
      sel5 = SW5'(s);
      #1;
      checks++;
      if (in_ready5 !== 5'h00) begin
        failures++;
        $display("FAIL n5_oob_ready[sel=%0d] got=%h exp=00", s, in_ready5);
      end
      @(posedge clock);
      #1;
      checks++;
      if (out_valid5 !== 1'b0) begin
        failures++;
        $display("FAIL n5_oob_valid[sel=%0d] got=%0b exp=0", s, out_valid5);
      end
      @(negedge clock);
    end
    sel5 = 3'd4;
    #1;
    checks++;
    if (in_ready5 !== 5'h10) begin
      failures++;
      $display("FAIL n5_sel4_ready got=%h exp=10", in_ready5);
    end
    @(posedge clock);
    #1;
    checks++;
    if (out_valid5 !== 1'b1 || out_chan5 !== 3'd4 || out_data5 !== 8'h54) begin
      failures++;
      $display("FAIL n5_sel4_out got valid=%0b chan=%0d data=%h exp valid=1 chan=4 data=54",
               out_valid5, out_chan5, out_data5);
    end
    @(negedge clock);
    rr_en5 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(posedge clock);
      #1;
      checks++;
      if (out_chan5 !== SW5'(c % N5) || out_data5 !== W5'(8'h50 + c % N5)) begin
        failures++;
        $display("FAIL n5_rr[%0d] got chan=%0d data=%h exp chan=%0d data=%h",
                 c, out_chan5, out_data5, c % N5, 8'h50 + c % N5);
      end
      @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_sel();
    test_rr_wrap();
    test_backpressure();
    test_sparse();
    test_random();
    test_n5();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
